// File: rtl/button_interface_if.sv
// Decoder-side bus for the button window: clear-strobe/write-data in, register image out.
interface button_interface_if;
    logic        clear_we;
    logic [31:0] clear_data;
    logic [31:0] read_data;

    modport master (
        output clear_we,
        output clear_data,
        input  read_data
    );

    modport slave (
        input  clear_we,
        input  clear_data,
        output read_data
    );
endinterface

// File: rtl/button_interface.sv
// Push-button peripheral: two-flop synchroniser, per-button debounce counter,
// sticky press flags cleared by write-one, combinational register image.
module button_interface #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] buttons_in,
    button_interface_if.slave    bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BUTTONS-1:0] sync1;
    logic [N_BUTTONS-1:0] sync2;
    logic [N_BUTTONS-1:0] stable;
    logic [N_BUTTONS-1:0] pressed;
    logic [CNT_W-1:0]     cnt [N_BUTTONS];

    logic [N_BUTTONS-1:0] stable_nxt;
    logic [N_BUTTONS-1:0] pressed_nxt;
    logic [N_BUTTONS-1:0] rise;
    logic [N_BUTTONS-1:0] clear_mask;
    logic [CNT_W-1:0]     cnt_nxt [N_BUTTONS];

    // Only bits 16+i of the write data carry meaning; the rest are ignored.
    logic                 unused_clear_data;
    assign unused_clear_data = ^bus.clear_data;

    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < N_BUTTONS; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A rising stable edge on the same cycle as a clear keeps the flag set.
    always_comb begin
        rise        = stable_nxt & ~stable;
        clear_mask  = bus.clear_we ? bus.clear_data[16 +: N_BUTTONS] : '0;
        pressed_nxt = (pressed & ~clear_mask) | rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            stable  <= '0;
            pressed <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= buttons_in;
            sync2   <= sync1;
            stable  <= stable_nxt;
            pressed <= pressed_nxt;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    always_comb begin
        bus.read_data                   = '0;
        bus.read_data[N_BUTTONS-1:0]    = stable;
        bus.read_data[16 +: N_BUTTONS]  = pressed;
    end

endmodule
